// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array: FSM encoding,
// default geometry and the accumulator width rule.
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } sa_state_e;

  localparam int SA_N_DEF  = 5;
  localparam int SA_DW_DEF = 8;

  // Wide enough for N full-scale products without overflow.
  function automatic int sa_acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/param_pe.sv
// One multiply-accumulate cell: activation is passed right, partial sum down,
// both registered.
module param_pe #(
  parameter int DW     = 8,
  parameter int AW     = 19,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [DW-1:0] act_in,
  input  logic [DW-1:0] weight,
  input  logic [AW-1:0] psum_in,
  output logic [DW-1:0] act_out,
  output logic [AW-1:0] psum_out
);

  logic [DW-1:0] act_q, act_d;
  logic [AW-1:0] psum_q, psum_d;
  logic [AW-1:0] act_ext, w_ext;

  // Low AW bits of the AW x AW product are exact for both signednesses.
  always_comb begin
    act_ext = {{(AW-DW){SIGNED && act_in[DW-1]}}, act_in};
    w_ext   = {{(AW-DW){SIGNED && weight[DW-1]}}, weight};
    act_d   = clear ? '0 : act_in;
    psum_d  = clear ? '0 : psum_in + act_ext * w_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      psum_q <= '0;
    end else begin
      act_q  <= act_d;
      psum_q <= psum_d;
    end
  end

  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/param_systolic_array.sv
// N x N weight-stationary systolic array with skewed inputs, deskewed outputs
// and a shadow weight bank that is committed only when the pipeline is empty.
module param_systolic_array
  import sa_pkg::*;
#(
  parameter int N      = SA_N_DEF,
  parameter int DW     = SA_DW_DEF,
  parameter int AW     = sa_acc_width(N, DW),
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  output logic            out_valid,
  output logic [N*AW-1:0] out_data,
  output sa_state_e       dbg_state
);

  localparam int NW = N * N;
  localparam int CW = $clog2(NW) + 1;
  localparam int VS = 2 * N - 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NW - 1);

  // Handshake: a beat transfers on a rising edge with valid && ready both
  // high; a simultaneous clear discards it. Ready never depends on valid.
  sa_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] shadow_q [NW];
  logic [DW-1:0] shadow_d [NW];
  logic [DW-1:0] active_q [NW];
  logic [DW-1:0] active_d [NW];
  logic [VS-1:0] valid_q, valid_d;
  logic          in_fire, w_fire;

  assign in_ready  = ready_q & ~rst;
  assign w_ready   = ready_q & ~rst;
  assign in_fire   = in_valid & in_ready & ~clear;
  assign w_fire    = w_valid & w_ready & ~clear;
  assign out_valid = valid_q[VS-1];
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_fire) begin
          for (int k = 0; k < NW; k++) begin
            if (cnt_q == CW'(k)) shadow_d[k] = w_data;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN:  if (valid_q == '0) state_d = S_COMMIT;
      S_COMMIT: begin
        active_d = shadow_q;
        state_d  = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    if (clear && (state_q == S_LOAD || state_q == S_DRAIN)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      for (int k = 0; k < NW; k++) shadow_d[k] = '0;
    end
    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_fire;
    if (!clear) begin
      for (int k = 1; k < VS; k++) valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= '0;
      for (int k = 0; k < NW; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  logic [DW-1:0] act_w  [N][N+1];
  logic [AW-1:0] psum_w [N+1][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    logic [DW-1:0] x_in;
    assign x_in = in_fire ? in_data[i*DW +: DW] : '0;
    if (i == 0) begin : g_noskew
      assign act_w[i][0] = x_in;
    end else begin : g_skew
      logic [DW-1:0] skew_q [i];
      logic [DW-1:0] skew_d [i];
      always_comb begin
        for (int k = 0; k < i; k++) skew_d[k] = '0;
        if (!clear) begin
          skew_d[0] = x_in;
          for (int k = 1; k < i; k++) skew_d[k] = skew_q[k-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < i; k++) skew_q[k] <= '0;
        end else begin
          skew_q <= skew_d;
        end
      end
      assign act_w[i][0] = skew_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_row
    for (genvar j = 0; j < N; j++) begin : g_pe_col
      param_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .act_in   (act_w[i][j]),
        .weight   (active_q[i*N+j]),
        .psum_in  (psum_w[i][j]),
        .act_out  (act_w[i][j+1]),
        .psum_out (psum_w[i+1][j])
      );
    end
  end

  // Column j finishes j cycles after column 0; pad so all columns align.
  for (genvar j = 0; j < N; j++) begin : g_col
    assign psum_w[0][j] = '0;
    if (j == N - 1) begin : g_nodeskew
      assign out_data[j*AW +: AW] = psum_w[N][j];
    end else begin : g_deskew
      localparam int D = N - 1 - j;
      logic [AW-1:0] dsk_q [D];
      logic [AW-1:0] dsk_d [D];
      always_comb begin
        for (int k = 0; k < D; k++) dsk_d[k] = '0;
        if (!clear) begin
          dsk_d[0] = psum_w[N][j];
          for (int k = 1; k < D; k++) dsk_d[k] = dsk_q[k-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dsk_q[k] <= '0;
        end else begin
          dsk_q <= dsk_d;
        end
      end
      assign out_data[j*AW +: AW] = dsk_q[D-1];
    end
  end

endmodule

// File: tb/tb_param_systolic_array.sv
// Directed bench for param_systolic_array: an unsigned and a signed instance
// share all inputs and are checked against a scoreboard and fixed constants.
module tb_param_systolic_array;
  import sa_pkg::*;

  localparam int N   = 5;
  localparam int DW  = 8;
  localparam int AW  = 19;
  localparam int NW  = N * N;
  localparam int LAT = 2 * N - 1;

  logic clk, rst, clear, in_valid, w_valid;
  logic [N*DW-1:0] in_data;
  logic [DW-1:0]   w_data;
  logic in_ready, w_ready, out_valid;
  logic [N*AW-1:0] out_data;
  sa_state_e dbg_state;
  logic s_in_ready, s_w_ready, s_out_valid;
  logic [N*AW-1:0] s_out_data;
  sa_state_e s_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int run      = 0;
  int max_run  = 0;
  int p0;

  logic [N*AW-1:0] exp_q[$];
  logic [N*AW-1:0] exp_s_q[$];
  int              acc_q[$];
  logic [N*AW-1:0] e_u, e_s, last_u, last_s;
  int              a_cyc;

  logic [DW-1:0] wm    [NW];
  logic [DW-1:0] w_id  [NW];
  logic [DW-1:0] w_row [NW];
  logic [DW-1:0] w_ff  [NW];
  logic [DW-1:0] w_80  [NW];
  logic [N*DW-1:0] xv;

  param_systolic_array u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .out_valid(out_valid), .out_data(out_data), .dbg_state(dbg_state)
  );

  param_systolic_array #(.SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(s_w_ready), .w_data(w_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*AW-1:0] model(input logic [N*DW-1:0] x,
                                           input logic [DW-1:0] w [NW], input bit sgn);
    logic [N*AW-1:0] r;
    longint acc, xi, wi;
    r = '0;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) begin
        if (sgn) begin
          xi = longint'($signed(x[i*DW +: DW]));
          wi = longint'($signed(w[i*N+j]));
        end else begin
          xi = longint'(x[i*DW +: DW]);
          wi = longint'(w[i*N+j]);
        end
        acc += xi * wi;
      end
      r[j*AW +: AW] = acc[AW-1:0];
    end
    return r;
  endfunction

  // driver tasks
  task automatic send_vec(input logic [N*DW-1:0] x);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(model(x, wm, 1'b0));
      exp_s_q.push_back(model(x, wm, 1'b1));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [DW-1:0] w [NW], input int abort_at);
    int guard;
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_data  = w[k];
      clear   = (k == abort_at);
      guard = 0;
      while (!w_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!w_ready) check("w_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      clear   = 1'b0;
      if (k == abort_at) begin
        exp_q.delete();
        exp_s_q.delete();
        acc_q.delete();
        return;
      end
    end
    @(negedge clk);
    check("in_ready_after_last_beat", 32'(in_ready), 32'd0);
    check("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    wm = w;
    guard = 0;
    while (!w_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("commit_done", 32'(w_ready), 32'd1);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
      else begin
        e_u   = exp_q.pop_front();
        e_s   = exp_s_q.pop_front();
        a_cyc = acc_q.pop_front();
        check("latency", cyc - a_cyc, LAT);
        for (int j = 0; j < N; j++) begin
          check("col_u", 32'(out_data[j*AW +: AW]), 32'(e_u[j*AW +: AW]));
          check("col_s", 32'(s_out_data[j*AW +: AW]), 32'(e_s[j*AW +: AW]));
        end
        last_u = out_data;
        last_s = s_out_data;
      end
      check("s_out_valid", 32'(s_out_valid), 32'd1);
    end else begin
      run = 0;
      if (s_out_valid) check("s_spurious_out_valid", 32'd1, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; w_valid = 1'b0;
    in_data = '0; w_data = '0; last_u = '1; last_s = '1;
    for (int k = 0; k < NW; k++) begin
      wm[k]    = '0;
      w_id[k]  = (k / N == k % N) ? 8'd1 : 8'd0;
      w_row[k] = 8'(k / N + 1);
      w_ff[k]  = 8'hFF;
      w_80[k]  = 8'h80;
    end

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    for (int j = 0; j < N; j++) check("rst_out_data", 32'(out_data[j*AW +: AW]), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd0);
    check("rst_s_in_ready", 32'(s_in_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_w_ready", 32'(s_w_ready), 32'd1);
    check("rel_s_state", 32'(s_dbg_state), 32'(S_IDLE));

    // identity weights, single vector
    load_weights(w_id, -1);
    p0 = pulses;
    send_vec({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    repeat (14) @(negedge clk);
    check("ident_pulses", pulses - p0, 32'd1);
    for (int j = 0; j < N; j++) check("ident_col", 32'(last_u[j*AW +: AW]), 32'(j + 1));

    // per-row weights, 10 back-to-back vectors of ones
    load_weights(w_row, -1);
    p0 = pulses;
    max_run = 0;
    for (int k = 0; k < 10; k++) send_vec({5{8'd1}});
    repeat (14) @(negedge clk);
    check("row_pulses", pulses - p0, 32'd10);
    check("row_contiguous", max_run, 32'd10);
    for (int j = 0; j < N; j++) begin
      check("row_col_u", 32'(last_u[j*AW +: AW]), 32'd15);
      check("row_col_s", 32'(last_s[j*AW +: AW]), 32'd15);
    end

    // all-ones weights: full-scale unsigned, -1 signed
    load_weights(w_ff, -1);
    send_vec({5{8'hFF}});
    repeat (14) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      check("max_col_u", 32'(last_u[j*AW +: AW]), 32'd325125);
      check("max_col_s", 32'(last_s[j*AW +: AW]), 32'd5);
    end
    send_vec({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    repeat (14) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      check("neg_col_u", 32'(last_u[j*AW +: AW]), 32'd3825);
      check("neg_col_s", 32'(last_s[j*AW +: AW]), 32'h7FFF1);
    end

    // reload to identity while vectors stream
    fork
      for (int k = 0; k < 30; k++) begin
        for (int i = 0; i < N; i++) xv[i*DW +: DW] = 8'(k + i);
        send_vec(xv);
      end
      begin
        repeat (3) @(negedge clk);
        load_weights(w_id, -1);
      end
    join
    repeat (14) @(negedge clk);
    check("reload_drained", exp_q.size(), 32'd0);
    for (int j = 0; j < N; j++) check("reload_last_col", 32'(last_u[j*AW +: AW]), 32'(29 + j));

    // clear on load beat 12 with vectors in flight
    p0 = pulses;
    fork
      load_weights(w_80, 12);
      begin
        repeat (8) @(negedge clk);
        for (int k = 0; k < 3; k++) send_vec({5{8'd3}});
      end
    join
    @(negedge clk);
    check("clear_state", 32'(dbg_state), 32'(S_IDLE));
    check("clear_ready", 32'(w_ready), 32'd1);
    repeat (15) @(negedge clk);
    check("clear_no_out", pulses - p0, 32'd0);
    send_vec({8'd15, 8'd13, 8'd11, 8'd9, 8'd7});
    repeat (14) @(negedge clk);
    for (int j = 0; j < N; j++) check("clear_old_w", 32'(last_u[j*AW +: AW]), 32'(7 + 2 * j));

    // most negative operands
    load_weights(w_80, -1);
    send_vec({5{8'h80}});
    repeat (14) @(negedge clk);
    for (int j = 0; j < N; j++) begin
      check("m128_col_s", 32'(last_s[j*AW +: AW]), 32'd81920);
      check("m128_col_u", 32'(last_u[j*AW +: AW]), 32'd81920);
    end

    // reset with four vectors in flight
    for (int k = 0; k < 4; k++) send_vec({5{8'd2}});
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_s_q.delete();
    acc_q.delete();
    for (int k = 0; k < NW; k++) wm[k] = '0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    for (int j = 0; j < N; j++) check("mid_rst_out_data", 32'(out_data[j*AW +: AW]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    p0 = pulses;
    repeat (15) @(negedge clk);
    check("post_rst_no_out", pulses - p0, 32'd0);
    send_vec({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    repeat (14) @(negedge clk);
    check("post_rst_pulse", pulses - p0, 32'd1);
    for (int j = 0; j < N; j++) begin
      check("post_rst_col_u", 32'(last_u[j*AW +: AW]), 32'd0);
      check("post_rst_col_s", 32'(last_s[j*AW +: AW]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
